// File: rtl/vga_pkg.sv
// Shared VGA timing, framebuffer geometry and colour width used by the scanner and the renderers.
package vga_pkg;

    localparam int unsigned FB_WIDTH      = 160;
    localparam int unsigned FB_HEIGHT     = 120;
    localparam int unsigned FB_SCALE_LOG2 = 2;
    // Row pitch of the framebuffer; the address math below is built around it.
    localparam int unsigned FB_STRIDE     = 160;

    localparam int unsigned COLOUR_W = 3;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = 15;

    typedef logic [COLOUR_W-1:0] colour_t;

    // row*160 + col as two shifts and an add.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
        logic [ADDR_W-1:0] r;
        r = {8'd0, row};
        return (r << 7) + (r << 5) + {7'd0, col};
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port framebuffer RAM: synchronous write, registered read (old data on collision).
module frame_ram
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = FB_STRIDE * FB_HEIGHT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  colour_t       wr_data,
    input  logic [AW-1:0] rd_addr,
    output colour_t       rd_data
);

    colour_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_frame_scanner.sv
// Framebuffer write port plus a 640x480@60 scan-out with 2-clock colour pipeline and frame pulse.
module vga_frame_scanner
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH      = FB_WIDTH,
    parameter int unsigned HEIGHT     = FB_HEIGHT,
    parameter int unsigned SCALE_LOG2 = FB_SCALE_LOG2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          vga_x,
    input  logic [6:0]          vga_y,
    input  logic [COLOUR_W-1:0] vga_colour,
    input  logic                vga_write,
    output logic [7:0]          vga_r,
    output logic [7:0]          vga_g,
    output logic [7:0]          vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_blank_n,
    output logic                vga_pix_en,
    output logic                frame_done
);

    localparam int unsigned H_VIS     = WIDTH << SCALE_LOG2;
    localparam int unsigned H_TOTAL   = H_VIS + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_VIS     = HEIGHT << SCALE_LOG2;
    localparam int unsigned V_TOTAL   = V_VIS + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned RAM_DEPTH = FB_STRIDE * HEIGHT;
    localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);

    localparam logic [CNT_W-1:0] H_VIS_C   = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] H_SS_C    = CNT_W'(H_VIS + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE_C    = CNT_W'(H_VIS + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS_C   = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] V_VLAST_C = CNT_W'(V_VIS - 1);
    localparam logic [CNT_W-1:0] V_SS_C    = CNT_W'(V_VIS + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE_C    = CNT_W'(V_VIS + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);

    // ---------------- write port ----------------
    logic              wr_ok;
    logic [RAM_AW-1:0] wr_addr;

    assign wr_ok   = vga_write && (vga_x < 8'(WIDTH)) && (vga_y < 7'(HEIGHT));
    assign wr_addr = RAM_AW'(fb_addr(vga_y, vga_x));

    // ---------------- timing counters (S0) ----------------
    logic             ph;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             line_end;

    assign line_end   = (hc == H_LAST_C);
    assign vga_pix_en = ph;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph         <= 1'b0;
            hc         <= '0;
            vc         <= '0;
            frame_done <= 1'b0;
        end else begin
            ph         <= ~ph;
            // Fires on the same enabled tick that moves vc into vertical blanking.
            frame_done <= ph && line_end && (vc == V_VLAST_C);
            if (ph) begin
                if (line_end) begin
                    hc <= '0;
                    vc <= (vc == V_LAST_C) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
            end
        end
    end

    logic              s0_vis;
    logic              s0_hs_n;
    logic              s0_vs_n;
    logic [RAM_AW-1:0] rd_addr;

    assign s0_vis  = (hc < H_VIS_C) && (vc < V_VIS_C);
    assign s0_hs_n = !((hc >= H_SS_C) && (hc < H_SE_C));
    assign s0_vs_n = !((vc >= V_SS_C) && (vc < V_SE_C));
    assign rd_addr = RAM_AW'(fb_addr(7'(vc >> SCALE_LOG2), 8'(hc >> SCALE_LOG2)));

    // ---------------- framebuffer (S1 read register) ----------------
    colour_t rd_data;

    frame_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_frame_ram (
        .clock   (clock),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (vga_colour),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // ---------------- sync/blank delay and output registers (S1, S2) ----------------
    logic s1_blank;
    logic s1_hs;
    logic s1_vs;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_blank    <= 1'b1;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
        end else begin
            s1_blank    <= !s0_vis;
            s1_hs       <= s0_hs_n;
            s1_vs       <= s0_vs_n;
            vga_blank_n <= !s1_blank;
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            vga_r       <= s1_blank ? 8'h00 : {8{rd_data[2]}};
            vga_g       <= s1_blank ? 8'h00 : {8{rd_data[1]}};
            vga_b       <= s1_blank ? 8'h00 : {8{rd_data[0]}};
        end
    end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Directed bench for vga_frame_scanner on a reduced 160x4 framebuffer with 2x2 replication,
// which keeps a full frame (480 x 53 ticks) short enough to scan end to end.
`timescale 1ns/1ps
module tb_vga_frame_scanner;

    localparam int unsigned TB_WIDTH      = 160;
    localparam int unsigned TB_HEIGHT     = 4;
    localparam int unsigned TB_SCALE_LOG2 = 1;

    // Hand-derived geometry: H = 320+16+96+48 = 480, V = 8+10+2+33 = 53.
    localparam int H_TOTAL    = 480;
    localparam int V_TOTAL    = 53;
    localparam int H_VIS      = 320;
    localparam int V_VIS      = 8;
    localparam int FRAME_CLKS = 50880;
    localparam int FD_FIRST   = 7680;
    localparam int SCAN_CLKS  = 58570;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_pix_en, frame_done;

    always #10 clock = ~clock;

    vga_frame_scanner #(
        .WIDTH      (TB_WIDTH),
        .HEIGHT     (TB_HEIGHT),
        .SCALE_LOG2 (TB_SCALE_LOG2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_write   (vga_write),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_pix_en  (vga_pix_en),
        .frame_done  (frame_done)
    );

    // Posedges seen since the last reset release.
    int n;
    always @(posedge clock or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    int n_cmp;
    int n_err;
    logic [2:0] fb [TB_HEIGHT][TB_WIDTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_hs"},         32'(vga_hs),      32'd1);
        check({pfx, "_vs"},         32'(vga_vs),      32'd1);
        check({pfx, "_blank_n"},    32'(vga_blank_n), 32'd0);
        check({pfx, "_rgb"},        32'({vga_r, vga_g, vga_b}), 32'd0);
        check({pfx, "_pix_en"},     32'(vga_pix_en),  32'd0);
        check({pfx, "_frame_done"}, 32'(frame_done),  32'd0);
    endtask

    // Inputs change on the falling edge; returns on the next falling edge.
    task automatic wr(input int x, input int y, input logic [2:0] c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = c;
        vga_write  = 1'b1;
        if (x < TB_WIDTH && y < TB_HEIGHT) fb[2'(y)][8'(x)] = c;
        @(negedge clock);
        vga_write  = 1'b0;
    endtask

    initial begin
        int         p, hx, vy, guard;
        logic       e_vis, e_hs, e_vs, e_fd, e_pe;
        logic [2:0] e_col;
        logic [23:0] e_rgb, got_rgb;
        int err_blank, err_hs, err_vs, err_rgb, err_pe, err_fd;
        int red_cnt, cyan_cnt, green_cnt;
        int fd_first, fd_second;
        int hs_fall, hs_rise, vs_fall, vs_rise;
        logic hs_prev, vs_prev;
        logic [23:0] px_00, px_01, px_95_1, px_last;

        n_cmp = 0;
        n_err = 0;
        vga_x = '0;
        vga_y = '0;
        vga_colour = '0;
        vga_write = 1'b0;

        for (int i = 0; i < 4; i++) @(negedge clock);
        check_reset_outputs("por");
        reset = 1'b1;

        for (int y = 0; y < TB_HEIGHT; y++)
            for (int x = 0; x < TB_WIDTH; x++) wr(x, y, 3'b000);
        wr(0, 0, 3'b100);
        wr(159, 3, 3'b011);
        wr(19, 1, 3'b010);
        wr(160, 0, 3'b111);
        wr(255, 0, 3'b111);
        wr(0, 4, 3'b111);
        wr(0, 120, 3'b111);

        // Tick 999 = row 2 of the scan, inside the green (19,1) block, with ph high.
        guard = 0;
        while (n != 2001 && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        check("wait_mid_frame", 32'(n), 32'd2001);
        check("pre_reset_g", 32'(vga_g), 32'hFF);
        check("pre_reset_pix_en", 32'(vga_pix_en), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("mid");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        err_blank = 0; err_hs = 0; err_vs = 0; err_rgb = 0; err_pe = 0; err_fd = 0;
        red_cnt = 0; cyan_cnt = 0; green_cnt = 0;
        fd_first = -1; fd_second = -1;
        hs_fall = -1; hs_rise = -1; vs_fall = -1; vs_rise = -1;
        hs_prev = 1'b1; vs_prev = 1'b1;
        px_00 = 'x; px_01 = 'x; px_95_1 = 'x; px_last = 'x;

        for (int i = 0; i < SCAN_CLKS; i++) begin
            @(negedge clock);
            if (n < 2) begin
                e_vis = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_col = 3'b000;
            end else begin
                p     = ((n - 2) / 2) % (H_TOTAL * V_TOTAL);
                hx    = p % H_TOTAL;
                vy    = p / H_TOTAL;
                e_vis = (hx < H_VIS) && (vy < V_VIS);
                e_hs  = !(hx >= 336 && hx < 432);
                e_vs  = !(vy >= 18 && vy < 20);
                e_col = e_vis ? fb[2'(vy >> 1)][8'(hx >> 1)] : 3'b000;
            end
            e_pe    = n[0];
            e_fd    = (n >= FD_FIRST) && (((n - FD_FIRST) % FRAME_CLKS) == 0);
            e_rgb   = {{8{e_col[2]}}, {8{e_col[1]}}, {8{e_col[0]}}};
            got_rgb = {vga_r, vga_g, vga_b};

            if (vga_blank_n !== e_vis) err_blank++;
            if (vga_hs !== e_hs)       err_hs++;
            if (vga_vs !== e_vs)       err_vs++;
            if (got_rgb !== e_rgb)     err_rgb++;
            if (vga_pix_en !== e_pe)   err_pe++;
            if (frame_done !== e_fd)   err_fd++;

            if (n < FRAME_CLKS) begin
                if (got_rgb == 24'hFF0000) red_cnt++;
                if (got_rgb == 24'h00FFFF) cyan_cnt++;
                if (got_rgb == 24'h00FF00) green_cnt++;
            end
            if (n == 2)    px_00   = got_rgb;
            if (n == 1922) px_01   = got_rgb;
            if (n == 2302) px_95_1 = got_rgb;
            if (n == 6398) px_last = got_rgb;

            if (frame_done === 1'b1) begin
                if (fd_first < 0)       fd_first = n;
                else if (fd_second < 0) fd_second = n;
            end
            if (hs_prev && !vga_hs && hs_fall < 0) hs_fall = n;
            if (!hs_prev && vga_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = n;
            if (vs_prev && !vga_vs && vs_fall < 0) vs_fall = n;
            if (!vs_prev && vga_vs && vs_fall >= 0 && vs_rise < 0) vs_rise = n;
            hs_prev = vga_hs;
            vs_prev = vga_vs;
        end

        check("scan_blank_n_errs", 32'(err_blank), 32'd0);
        check("scan_hs_errs",      32'(err_hs),    32'd0);
        check("scan_vs_errs",      32'(err_vs),    32'd0);
        check("scan_rgb_errs",     32'(err_rgb),   32'd0);
        check("scan_pix_en_errs",  32'(err_pe),    32'd0);
        check("scan_fd_errs",      32'(err_fd),    32'd0);

        check("red_clocks",   32'(red_cnt),   32'd8);
        check("cyan_clocks",  32'(cyan_cnt),  32'd8);
        check("green_clocks", 32'(green_cnt), 32'd8);

        check("px_0_0",       32'(px_00),   32'h00FF0000);
        check("px_0_1_alias", 32'(px_01),   32'h00000000);
        check("px_95_1_alias", 32'(px_95_1), 32'h00000000);
        check("px_159_3",     32'(px_last), 32'h0000FFFF);

        check("hs_fall_clk",  32'(hs_fall),           32'd674);
        check("hs_low_clks",  32'(hs_rise - hs_fall), 32'd192);
        check("vs_fall_clk",  32'(vs_fall),           32'd17282);
        check("vs_low_clks",  32'(vs_rise - vs_fall), 32'd1920);

        check("fd_first_clk", 32'(fd_first),             32'(FD_FIRST));
        check("fd_interval",  32'(fd_second - fd_first), 32'(FRAME_CLKS));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
